vga_pattern_gen: RTL and testbench



---
 rtl/vga_pattern_gen.sv | 166 ++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_pattern_gen
// Brief    : Test-pattern source for the VGA/TFT timing controller. Returns
//            one RGB888 word per Data_Req, one clock later. Modes: 0 colour
//            grid, 1 checkerboard, 2 grey ramp, 3 bouncing square. Mode and
//            square position change only at the frame-end pixel.
// Options  : PATGEN_BORDER_EN - force a 1-pixel white frame around the
//            active area in every mode.
// Revision : 1.0 - initial release
// ============================================================================
module vga_pattern_gen #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int ROWS     = 4,
    parameter int COLS     = 2,
    parameter int CNT_W    = 11,
    parameter int CHK_LOG2 = 5,
    parameter int SQ       = 64,
    parameter int STEP     = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Data_Req,
    input  logic [CNT_W-1:0] hcount,
    input  logic [CNT_W-1:0] vcount,
    input  logic [1:0]       mode,
    output logic [23:0]      disp_data,
    output logic             disp_vld
);

    localparam int COL_W = H_ACTIVE / COLS;
    localparam int ROW_H = V_ACTIVE / ROWS;

    localparam logic [CNT_W-1:0] X_MAX  = CNT_W'(H_ACTIVE - SQ);
    localparam logic [CNT_W-1:0] Y_MAX  = CNT_W'(V_ACTIVE - SQ);
    localparam logic [CNT_W-1:0] STEP_N = CNT_W'(STEP);
    localparam logic [CNT_W:0]   SQ_E   = (CNT_W+1)'(SQ);
    localparam logic [CNT_W:0]   STEP_E = (CNT_W+1)'(STEP);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE - 1);

    logic [23:0]      disp_data_q, disp_data_d;
    logic             disp_vld_q;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] sq_x_q, sq_x_d, sq_y_q, sq_y_d;
    logic             dx_q, dx_d, dy_q, dy_d;   // 1 = moving towards +x/+y

    logic             fe_w;
    logic [3:0]       col_w, row_w;
    logic [2:0]       idx_w;
    logic [23:0]      grid_w, pix_w;
    logic             in_sq_w;

    assign fe_w = Data_Req && (hcount == H_LAST) && (vcount == V_LAST);

    // Grid cell lookup: comparator chain against constant block edges, which
    // also clamps out-of-range coordinates into the last row/column.
    always_comb begin
        col_w = '0;
        row_w = '0;
        for (int k = 1; k < COLS; k++) begin
            if (32'(hcount) >= 32'(k * COL_W)) col_w = 4'(k);
        end
        for (int k = 1; k < ROWS; k++) begin
            if (32'(vcount) >= 32'(k * ROW_H)) row_w = 4'(k);
        end
        idx_w  = 3'(row_w * 4'(COLS) + col_w);
        // Palette index bits map to {G,R,B}
        grid_w = {{8{idx_w[1]}}, {8{idx_w[2]}}, {8{idx_w[0]}}};
    end

    // Square hit test, widened so sq_x+SQ cannot wrap
    always_comb begin
        in_sq_w = ({1'b0, hcount} >= {1'b0, sq_x_q}) &&
                  ({1'b0, hcount} <  ({1'b0, sq_x_q} + SQ_E)) &&
                  ({1'b0, vcount} >= {1'b0, sq_y_q}) &&
                  ({1'b0, vcount} <  ({1'b0, sq_y_q} + SQ_E));
    end

    // Pattern select on the frame-latched mode, optional border override
    always_comb begin
        pix_w = 24'h000000;
        case (mode_q)
            2'd0:    pix_w = grid_w;
            2'd1:    pix_w = (hcount[CHK_LOG2] ^ vcount[CHK_LOG2]) ? 24'hFFFFFF : 24'h000000;
            2'd2:    pix_w = {hcount[7:0], hcount[7:0], hcount[7:0]};
            default: pix_w = in_sq_w ? 24'hFF0000 : 24'h0000FF;
        endcase
`ifdef PATGEN_BORDER_EN
        if ((hcount == '0) || (hcount == H_LAST) ||
            (vcount == '0) || (vcount == V_LAST)) begin
            pix_w = 24'hFFFFFF;
        end
`endif
        disp_data_d = Data_Req ? pix_w : 24'h000000;
    end

    // Frame-end updates: latch mode, bounce the square off the clamp limits
    always_comb begin
        mode_d = mode_q;
        sq_x_d = sq_x_q;
        sq_y_d = sq_y_q;
        dx_d   = dx_q;
        dy_d   = dy_q;
        if (fe_w) begin
            mode_d = mode;
            if (dx_q) begin
                if (({1'b0, sq_x_q} + STEP_E) >= {1'b0, X_MAX}) begin
                    sq_x_d = X_MAX;
                    dx_d   = 1'b0;
                end else begin
                    sq_x_d = sq_x_q + STEP_N;
                end
            end else begin
                if (sq_x_q <= STEP_N) begin
                    sq_x_d = '0;
                    dx_d   = 1'b1;
                end else begin
                    sq_x_d = sq_x_q - STEP_N;
                end
            end
            if (dy_q) begin
                if (({1'b0, sq_y_q} + STEP_E) >= {1'b0, Y_MAX}) begin
                    sq_y_d = Y_MAX;
                    dy_d   = 1'b0;
                end else begin
                    sq_y_d = sq_y_q + STEP_N;
                end
            end else begin
                if (sq_y_q <= STEP_N) begin
                    sq_y_d = '0;
                    dy_d   = 1'b1;
                end else begin
                    sq_y_d = sq_y_q - STEP_N;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            disp_data_q <= 24'h000000;
            disp_vld_q  <= 1'b0;
            mode_q      <= 2'd0;
            sq_x_q      <= '0;
            sq_y_q      <= '0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
        end else begin
            disp_data_q <= disp_data_d;
            disp_vld_q  <= Data_Req;
            mode_q      <= mode_d;
            sq_x_q      <= sq_x_d;
            sq_y_q      <= sq_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
        end
    end

    assign disp_data = disp_data_q;
    assign disp_vld  = disp_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pattern_gen
// Brief    : Self-checking bench for vga_pattern_gen: directed points plus
//            randomized requests against a behavioural pixel/frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_pattern_gen;

    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 480;
    localparam int ROWS     = 4;
    localparam int COLS     = 2;
    localparam int CNT_W    = 11;
    localparam int CHK_LOG2 = 5;
    localparam int SQ       = 64;
    localparam int STEP     = 4;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Data_Req = 1'b0;
    logic [CNT_W-1:0] hcount = '0;
    logic [CNT_W-1:0] vcount = '0;
    logic [1:0]       mode = 2'd0;
    logic [23:0]      disp_data;
    logic             disp_vld;

    vga_pattern_gen #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .ROWS(ROWS), .COLS(COLS),
        .CNT_W(CNT_W), .CHK_LOG2(CHK_LOG2), .SQ(SQ), .STEP(STEP)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Data_Req(Data_Req), .hcount(hcount),
        .vcount(vcount), .mode(mode), .disp_data(disp_data), .disp_vld(disp_vld)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: frame-latched mode, square corner and direction
    int m_mode, m_x, m_y, m_dx, m_dy;

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] palette(input int i);
        logic [23:0] tbl [8] = '{24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
                                 24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF};
        return tbl[i % 8];
    endfunction

    function automatic logic [23:0] model_pix(input int h, input int v);
        int col, row;
        logic [23:0] p;
        case (m_mode)
            0: begin
                col = h / (H_ACTIVE / COLS);
                row = v / (V_ACTIVE / ROWS);
                if (col > COLS - 1) col = COLS - 1;
                if (row > ROWS - 1) row = ROWS - 1;
                p = palette(row * COLS + col);
            end
            1: p = ((((h >> CHK_LOG2) ^ (v >> CHK_LOG2)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            2: p = 24'((h % 256) * 32'h010101);
            default: p = (h >= m_x && h < m_x + SQ && v >= m_y && v < m_y + SQ)
                         ? 24'hFF0000 : 24'h0000FF;
        endcase
`ifdef PATGEN_BORDER_EN
        if (h == 0 || h == H_ACTIVE - 1 || v == 0 || v == V_ACTIVE - 1) p = 24'hFFFFFF;
`endif
        return p;
    endfunction

    // One-axis bounce: returns new position, updates direction
    function automatic int bounce(input int pos, inout int dir, input int lim);
        if (dir > 0) begin
            if (pos + STEP >= lim) begin dir = -1; return lim; end
            return pos + STEP;
        end
        if (pos <= STEP) begin dir = 1; return 0; end
        return pos - STEP;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_x = 0; m_y = 0; m_dx = 1; m_dy = 1;
    endtask

    // Apply one cycle of inputs, predict, then compare after the edge
    task automatic drive(input bit rst, input bit req, input int h, input int v, input int m);
        logic [23:0] exp_d;
        logic        exp_v;
        int          hh, vv;
        hh = h % 2048;
        vv = v % 2048;
        Reset    = rst;
        Data_Req = req;
        hcount   = CNT_W'(hh);
        vcount   = CNT_W'(vv);
        mode     = 2'(m);
        if (rst) begin
            exp_d = 24'h0; exp_v = 1'b0;
            model_reset();
        end else begin
            exp_v = req;
            exp_d = req ? model_pix(hh, vv) : 24'h0;
            if (req && hh == H_ACTIVE - 1 && vv == V_ACTIVE - 1) begin
                m_mode = m;
                m_x = bounce(m_x, m_dx, H_ACTIVE - SQ);
                m_y = bounce(m_y, m_dy, V_ACTIVE - SQ);
            end
        end
        @(posedge Clk);
        #1;
        chk("vld", {23'd0, disp_vld}, {23'd0, exp_v});
        chk("data", disp_data, exp_d);
    endtask

    task automatic fe(input int m);
        drive(0, 1, H_ACTIVE - 1, V_ACTIVE - 1, m);
    endtask

    initial begin
        model_reset();

        // Reset held with Data_Req high
        for (int i = 0; i < 3; i++) drive(1, 1, 5, 5, 0);

        // Grid, default mode after reset
        drive(0, 1, 399, 0, 0);
`ifndef PATGEN_BORDER_EN
        chk("grid_399_0", disp_data, 24'h000000);
`endif
        drive(0, 1, 400, 0, 0);
`ifndef PATGEN_BORDER_EN
        chk("grid_400_0", disp_data, 24'h0000FF);
`endif
        drive(0, 1, 0, 360, 0);
`ifndef PATGEN_BORDER_EN
        chk("grid_0_360", disp_data, 24'hFFFF00);
`endif
        fe(0);
        drive(0, 1, 100, 200, 1);
        chk("grid_ignore_mode", disp_data, 24'hFF0000);
        drive(0, 1, 500, 300, 1);
        chk("grid_500_300", disp_data, 24'h00FFFF);
        fe(1);
`ifndef PATGEN_BORDER_EN
        chk("grid_fe_pixel", disp_data, 24'hFFFFFF);
`endif

        // Checker
        drive(0, 1, 32, 1, 1);
        chk("chk_32_1", disp_data, 24'hFFFFFF);
        drive(0, 1, 32, 32, 1);
        chk("chk_32_32", disp_data, 24'h000000);
        fe(2);

        // Ramp and idle request
        drive(0, 1, 300, 5, 2);
        chk("ramp_300", disp_data, 24'h2C2C2C);
        drive(0, 1, 255, 5, 2);
        chk("ramp_255", disp_data, 24'hFFFFFF);
        drive(0, 1, 10, 10, 2);
        chk("ramp_10", disp_data, 24'h0A0A0A);
        drive(0, 1, 0, 10, 2);
`ifdef PATGEN_BORDER_EN
        chk("border_0_10", disp_data, 24'hFFFFFF);
        drive(0, 1, 10, 479, 2);
        chk("border_10_479", disp_data, 24'hFFFFFF);
`else
        chk("noborder_0_10", disp_data, 24'h000000);
`endif
        drive(0, 0, 300, 5, 2);
        chk("idle_data", disp_data, 24'h000000);
        chk("idle_vld", {23'd0, disp_vld}, 24'd0);

        // Bouncing square from a fresh reset
        drive(1, 0, 0, 0, 3);
        for (int i = 0; i < 184; i++) fe(3);
        drive(0, 1, 736, 96, 3);
        chk("sq_184_in", disp_data, 24'hFF0000);
        drive(0, 1, 735, 96, 3);
        chk("sq_184_left", disp_data, 24'h0000FF);
        drive(0, 1, 736, 95, 3);
        chk("sq_184_above", disp_data, 24'h0000FF);
        fe(3);
        drive(0, 1, 732, 92, 3);
        chk("sq_185_in", disp_data, 24'hFF0000);
        drive(0, 1, 731, 92, 3);
        chk("sq_185_left", disp_data, 24'h0000FF);
        drive(0, 1, 795, 155, 3);
        chk("sq_185_corner", disp_data, 24'hFF0000);
        drive(0, 1, 796, 155, 3);
        chk("sq_185_right", disp_data, 24'h0000FF);

        // Randomized traffic, including frame ends, out-of-range and resets
        for (int i = 0; i < 4000; i++) begin
            int sel, h, v;
            sel = int'($urandom_range(0, 99));
            if (sel < 2) begin
                drive(1, $urandom_range(0, 1) == 1, 0, 0, int'($urandom_range(0, 3)));
            end else if (sel < 12) begin
                fe(int'($urandom_range(0, 3)));
            end else begin
                if (sel < 18) begin
                    h = int'($urandom_range(0, 2047));
                    v = int'($urandom_range(0, 2047));
                end else begin
                    h = int'($urandom_range(0, H_ACTIVE - 1));
                    v = int'($urandom_range(0, V_ACTIVE - 1));
                end
                drive(0, $urandom_range(0, 7) != 0, h, v, int'($urandom_range(0, 3)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
